// File: rtl/bp_pkg.sv
// Branch-prediction shared package.
// Holds the BTB/BHT geometry, the BTB flush FSM state type and the BTB entry
// layout. The BHT takes its set count and index width from SET_COUNT and
// INDEX_WIDTH here, so the two structures always index identically.
package bp_pkg;

  localparam int SET_COUNT   = 64;
  localparam int INDEX_WIDTH = 6;
  localparam int ADDR_WIDTH  = 64;
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2;

  // Last set visited by the flush walk.
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(SET_COUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_ZERO = {INDEX_WIDTH{1'b0}};
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

  // Sequential fetch step (one 4-byte instruction).
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } btb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-1:0] target;
  } btb_entry_t;

endpackage : bp_pkg

// File: rtl/btb_if.sv
// BTB bus interface.
// Groups the fetch-side lookup, the BHT coupling, the execute-side update and
// the flush request.
//   master : fetch/execute side - drives i_*, receives o_*
//   slave  : the BTB            - receives i_*, drives o_*
interface btb_if;
  import bp_pkg::*;

  logic [ADDR_WIDTH-1:0]  i_pc;
  logic                   i_bht_pred_taken;
  logic                   i_btb_update;
  logic                   i_branch_taken;
  logic [ADDR_WIDTH-1:0]  i_pc_exec;
  logic [ADDR_WIDTH-1:0]  i_target_exec;
  logic                   i_flush;
  logic [INDEX_WIDTH-1:0] o_set_index;
  logic [INDEX_WIDTH-1:0] o_set_index_exec;
  logic                   o_btb_hit;
  logic                   o_pred_taken;
  logic [ADDR_WIDTH-1:0]  o_next_pc;
  logic                   o_busy;

  modport master (
    output i_pc, i_bht_pred_taken, i_btb_update, i_branch_taken,
           i_pc_exec, i_target_exec, i_flush,
    input  o_set_index, o_set_index_exec, o_btb_hit, o_pred_taken,
           o_next_pc, o_busy
  );

  modport slave (
    input  i_pc, i_bht_pred_taken, i_btb_update, i_branch_taken,
           i_pc_exec, i_target_exec, i_flush,
    output o_set_index, o_set_index_exec, o_btb_hit, o_pred_taken,
           o_next_pc, o_busy
  );

endinterface : btb_if

// File: rtl/btb_flush_ctrl.sv
// BTB invalidate-all walk controller.
// Ports:
//   i_clk, i_arstn : clock, asynchronous active-low reset
//   flush_req      : start a walk (accepted only when idle)
//   busy           : walk in progress
//   clr_en         : clear the valid bit at clr_idx this cycle
//   clr_idx        : set being cleared
// The walk visits every set once, one per cycle, then returns to IDLE.
module btb_flush_ctrl
  import bp_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_arstn,
  input  logic                   flush_req,
  output logic                   busy,
  output logic                   clr_en,
  output logic [INDEX_WIDTH-1:0] clr_idx
);

  btb_state_t             state_r;
  btb_state_t             state_nxt_s;
  logic [INDEX_WIDTH-1:0] cnt_r;
  logic [INDEX_WIDTH-1:0] cnt_nxt_s;

  // State and walk counter registers.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_r <= IDLE;
      cnt_r   <= IDX_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; a request during the walk is ignored.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = IDX_ZERO;
        if (flush_req) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = IDX_ZERO;
        end else begin
          state_nxt_s = FLUSH;
          cnt_nxt_s   = cnt_r + IDX_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = IDX_ZERO;
      end
    endcase
  end

  // Outputs come straight from the registered state and counter.
  always_comb begin
    busy    = (state_r == FLUSH);
    clr_en  = (state_r == FLUSH);
    clr_idx = cnt_r;
  end

endmodule : btb_flush_ctrl

// File: rtl/btb.sv
// Direct-mapped Branch Target Buffer (fetch stage).
// Ports:
//   i_clk, i_arstn : clock, asynchronous active-low reset
//   bus (slave)    : lookup PC, BHT prediction, execute-stage update,
//                    flush request; set indices to the BHT, hit, predicted
//                    next PC and walk-busy flag.
// Lookup is combinational. Taken resolved branches install/overwrite the
// entry at their set. A flush walk clears every valid bit over SET_COUNT
// cycles; lookups miss and updates are dropped while it runs.
module btb
  import bp_pkg::*;
(
  input  logic i_clk,
  input  logic i_arstn,
  btb_if.slave bus
);

  logic [SET_COUNT-1:0]  valid_r;
  logic [TAG_WIDTH-1:0]  tag_r    [SET_COUNT];
  logic [ADDR_WIDTH-1:0] target_r [SET_COUNT];

  logic [INDEX_WIDTH-1:0] idx_s;
  logic [INDEX_WIDTH-1:0] idx_exec_s;
  logic [TAG_WIDTH-1:0]   tag_s;
  logic [TAG_WIDTH-1:0]   tag_exec_s;
  logic                   busy_s;
  logic                   clr_en_s;
  logic [INDEX_WIDTH-1:0] clr_idx_s;
  logic                   wr_en_s;
  logic                   hit_s;
  btb_entry_t             rd_entry_s;
  logic                   unused_ok_s;

  // PC field split; the byte-offset bits never take part.
  assign idx_s       = bus.i_pc[INDEX_WIDTH+1:2];
  assign idx_exec_s  = bus.i_pc_exec[INDEX_WIDTH+1:2];
  assign tag_s       = bus.i_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign tag_exec_s  = bus.i_pc_exec[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_ok_s = ^{bus.i_pc[1:0], bus.i_pc_exec[1:0]};

  btb_flush_ctrl u_flush_ctrl (
    .i_clk     (i_clk),
    .i_arstn   (i_arstn),
    .flush_req (bus.i_flush),
    .busy      (busy_s),
    .clr_en    (clr_en_s),
    .clr_idx   (clr_idx_s)
  );

  // Install on a taken resolution in IDLE; a same-cycle flush wins.
  always_comb begin
    wr_en_s = 1'b0;
    if (!busy_s && !bus.i_flush && bus.i_btb_update && bus.i_branch_taken) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Valid bits: cleared by reset and by the walk, set by installs.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      valid_r <= {SET_COUNT{1'b0}};
    end else if (clr_en_s) begin
      valid_r[clr_idx_s] <= 1'b0;
    end else if (wr_en_s) begin
      valid_r[idx_exec_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and target payload; qualified by valid so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      tag_r[idx_exec_s]    <= tag_exec_s;
      target_r[idx_exec_s] <= bus.i_target_exec;
    end
  end

  // Lookup reads the pre-write array, so a same-cycle install shows next cycle.
  always_comb begin
    rd_entry_s.valid  = valid_r[idx_s];
    rd_entry_s.tag    = tag_r[idx_s];
    rd_entry_s.target = target_r[idx_s];
    hit_s             = 1'b0;
    if (rd_entry_s.valid && (rd_entry_s.tag == tag_s) && !busy_s) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Output drive; the sequential PC add wraps with no carry out.
  always_comb begin
    bus.o_set_index      = idx_s;
    bus.o_set_index_exec = idx_exec_s;
    bus.o_btb_hit        = hit_s;
    bus.o_pred_taken     = hit_s & bus.i_bht_pred_taken;
    bus.o_busy           = busy_s;
    if (hit_s && bus.i_bht_pred_taken) begin
      bus.o_next_pc = rd_entry_s.target;
    end else begin
      bus.o_next_pc = bus.i_pc + PC_STEP;
    end
  end

endmodule : btb
